// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared types and helpers for the Pong score keeper.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Referee FSM states
    typedef enum logic [1:0] {
        ARMED    = 2'd0,
        CHECK    = 2'd1,
        WAIT_REL = 2'd2,
        OVER     = 2'd3
    } score_state_t;

    // Width of a player index; never less than one bit
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : pong_pkg
`default_nettype wire

// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper_if
// Brief    : Rally-result inputs and score/referee outputs of score_keeper.
// Revision : 1.0 - initial release
// ============================================================================
interface score_keeper_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4
);
    import pong_pkg::*;

    localparam int IDX_W = idx_w(NUM_PLAYERS);

    logic [NUM_PLAYERS-1:0]         point_win;
    logic                           new_game;
    logic [NUM_PLAYERS*SCORE_W-1:0] score;
    logic                           point_ack;
    logic                           tie_flag;
    logic [IDX_W-1:0]               serve;
    logic [IDX_W-1:0]               winner;
    logic                           done;

    // Game logic side: supplies rally results, consumes scores
    modport master (
        output point_win, new_game,
        input  score, point_ack, tie_flag, serve, winner, done
    );

    // Score keeper side
    modport slave (
        input  point_win, new_game,
        output score, point_ack, tie_flag, serve, winner, done
    );

endinterface : score_keeper_if
`default_nettype wire

// File: rtl/max_other.sv
`default_nettype none
// ============================================================================
// Module   : max_other
// Brief    : Combinational maximum of all scores except the one at idx.
// Revision : 1.0 - initial release
// ============================================================================
module max_other #(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    input  logic [IDX_W-1:0]               idx,
    output logic [SCORE_W-1:0]             max_val
);

    // Linear reduction over every player other than idx
    always_comb begin
        max_val = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if ((IDX_W'(i) != idx) && (scores[i*SCORE_W +: SCORE_W] > max_val)) begin
                max_val = scores[i*SCORE_W +: SCORE_W];
            end
        end
    end

endmodule : max_other
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module   : score_keeper
// Brief    : Point counter and match referee for Pong: one point per rally
//            assertion, first-to-WIN_SCORE / win-by-WIN_BY, rotating server.
// Revision : 1.0 - initial release
// ============================================================================
module score_keeper
    import pong_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 4,
    parameter int WIN_BY      = 1,
    parameter int SERVE_EVERY = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    score_keeper_if.slave  bus
);

    localparam int IDX_W = idx_w(NUM_PLAYERS);

    score_state_t                   state;
    logic [NUM_PLAYERS*SCORE_W-1:0] scores;
    logic [IDX_W-1:0]               cred;
    logic [IDX_W-1:0]               serve_idx;
    logic [3:0]                     serve_cnt;
    logic [IDX_W-1:0]               winner_idx;
    logic                           match_done;
    logic                           ack;
    logic                           tie;

    logic                           one_hit;
    logic                           multi_hit;
    logic [IDX_W-1:0]               hit_idx;
    logic [SCORE_W-1:0]             hit_score;
    logic [SCORE_W-1:0]             cred_score;
    logic [SCORE_W-1:0]             other_max;
    logic signed [SCORE_W:0]        lead;
    logic                           win_now;

    max_other #(
        .NUM_PLAYERS (NUM_PLAYERS),
        .SCORE_W     (SCORE_W),
        .IDX_W       (IDX_W)
    ) u_max_other (
        .scores  (scores),
        .idx     (cred),
        .max_val (other_max)
    );

    // Decode the rally result: which single player won, or a simultaneous claim
    always_comb begin
        multi_hit = (bus.point_win & (bus.point_win - NUM_PLAYERS'(1))) != '0;
        one_hit   = (bus.point_win != '0) && !multi_hit;
        hit_idx   = '0;
        for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
            if (bus.point_win[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
        hit_score = scores[hit_idx*SCORE_W +: SCORE_W];
    end

    // Win test on the registered score of the player credited last cycle;
    // a saturated counter ends the match regardless of lead
    always_comb begin
        cred_score = scores[cred*SCORE_W +: SCORE_W];
        lead       = $signed({1'b0, cred_score}) - $signed({1'b0, other_max});
        win_now    = ((cred_score >= SCORE_W'(WIN_SCORE)) &&
                      (lead >= $signed((SCORE_W+1)'(WIN_BY)))) ||
                     (cred_score == {SCORE_W{1'b1}});
    end

    // Referee FSM with registered outputs; new_game overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_REL;
            scores     <= '0;
            cred       <= '0;
            serve_idx  <= '0;
            serve_cnt  <= '0;
            winner_idx <= '0;
            match_done <= 1'b0;
            ack        <= 1'b0;
            tie        <= 1'b0;
        end else if (bus.new_game) begin
            state      <= WAIT_REL;
            scores     <= '0;
            cred       <= '0;
            serve_idx  <= '0;
            serve_cnt  <= '0;
            winner_idx <= '0;
            match_done <= 1'b0;
            ack        <= 1'b0;
            tie        <= 1'b0;
        end else begin
            ack <= 1'b0;
            tie <= 1'b0;
            case (state)
                ARMED: begin
                    if (one_hit) begin
                        if (hit_score != {SCORE_W{1'b1}}) begin
                            scores[hit_idx*SCORE_W +: SCORE_W] <= hit_score + SCORE_W'(1);
                        end
                        cred  <= hit_idx;
                        ack   <= 1'b1;
                        state <= CHECK;
                    end else if (multi_hit) begin
                        tie   <= 1'b1;
                        state <= WAIT_REL;
                    end
                end
                CHECK: begin
                    if (win_now) begin
                        winner_idx <= cred;
                        match_done <= 1'b1;
                        state      <= OVER;
                    end else begin
                        // Serve rotation is deferred to here so the
                        // match-ending point never moves the server
                        if (serve_cnt + 4'd1 >= 4'(SERVE_EVERY)) begin
                            serve_cnt <= '0;
                            if (serve_idx == IDX_W'(NUM_PLAYERS - 1)) begin
                                serve_idx <= '0;
                            end else begin
                                serve_idx <= serve_idx + IDX_W'(1);
                            end
                        end else begin
                            serve_cnt <= serve_cnt + 4'd1;
                        end
                        state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (bus.point_win == '0) begin
                        state <= ARMED;
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= WAIT_REL;
                end
            endcase
        end
    end

    assign bus.score     = scores;
    assign bus.point_ack = ack;
    assign bus.tie_flag  = tie;
    assign bus.serve     = serve_idx;
    assign bus.winner    = winner_idx;
    assign bus.done      = match_done;

endmodule : score_keeper
`default_nettype wire
